// File: rtl/imem_pkg.sv
// Shared types for the instruction-fetch slice: FSM states, buffer entry layout and
// the PC legality helper used by the controller.
package imem_pkg;

   localparam int IMEM_DATA_W = 32;
   localparam int IMEM_ADDR_W = 32;
   localparam int PC_STEP     = 4;

   typedef enum logic [1:0] {
      FETCH_RUN   = 2'd0,
      FETCH_HALT  = 2'd1,
      FETCH_FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [IMEM_ADDR_W-1:0] pc;
      logic [IMEM_DATA_W-1:0] instr;
   } fetch_entry_t;

   // A PC is unusable if it is not word aligned or its word index lies past the memory.
   function automatic logic pc_illegal(input logic [IMEM_ADDR_W-1:0] pc,
                                       input int unsigned mem_size);
      logic [31:0] word_idx;
      word_idx = 32'({2'b00, pc[IMEM_ADDR_W-1:2]});
      return (pc[1:0] != 2'b00) || (word_idx >= mem_size);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous buffer of fetched {pc, instruction} pairs; a synchronous flush
// empties it on redirects and takes precedence over a simultaneous pop.
module fetch_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t wdata_i,
   output fetch_entry_t head_o,
   output logic         valid_o,
   output logic         full_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(DEPTH - 1);

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             do_push_s, do_pop_s;

   // Pointer and occupancy next-state; flush discards everything, including a pop.
   always_comb begin
      do_push_s = push_i && !flush_i;
      do_pop_s  = pop_i && valid_q && !flush_i;
      wr_d      = wr_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push_s) begin
            wr_d = (wr_q + PTR_W'(1)) & PTR_MASK;
         end else begin
            wr_d = wr_q;
         end
         if (do_pop_s) begin
            rd_d = (rd_q + PTR_W'(1)) & PTR_MASK;
         end else begin
            rd_d = rd_q;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
      valid_d = (cnt_d != '0);
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         if (do_push_s) begin
            mem_q[wr_q] <= wdata_i;
         end
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign head_o  = mem_q[rd_q];
   assign valid_o = valid_q;
   assign full_o  = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/imem_fetch_controller.sv
// Program-counter owner for the combinational instruction memory: fetches one word per
// cycle into the fetch buffer and handles redirects, halts and address faults.
module imem_fetch_controller
   import imem_pkg::*;
#(
   parameter int DATA_WIDTH    = IMEM_DATA_W,
   parameter int ADDRESS_WIDTH = IMEM_ADDR_W,
   parameter int MEM_SIZE      = 256,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0,
   parameter int FIFO_DEPTH    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic [ADDRESS_WIDTH-1:0] imem_address,
   input  logic [DATA_WIDTH-1:0]    imem_instruction,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   input  logic                     halt_req,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [DATA_WIDTH-1:0]    instr_out,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   output logic                     fault,
   output logic [ADDRESS_WIDTH-1:0] fault_pc
);

   fetch_state_t             state_q;
   logic [ADDRESS_WIDTH-1:0] pc_q;
   logic [ADDRESS_WIDTH-1:0] fault_pc_q;
   logic                     fault_q;

   logic         pc_bad_s, pop_s, space_s, fe_s;
   logic         fifo_valid_s, fifo_full_s;
   fetch_entry_t push_entry_s, head_s;

   // Fetch enable: a full buffer still accepts a push when decode pops in the same cycle.
   always_comb begin
      pc_bad_s           = pc_illegal(pc_q, MEM_SIZE);
      pop_s              = fifo_valid_s && instr_ready;
      space_s            = !fifo_full_s || pop_s;
      fe_s               = (state_q == FETCH_RUN) && !redirect_valid && !pc_bad_s
                           && !halt_req && space_s;
      push_entry_s.pc    = pc_q;
      push_entry_s.instr = imem_instruction;
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fe_s),
      .pop_i   (pop_s),
      .flush_i (redirect_valid),
      .wdata_i (push_entry_s),
      .head_o  (head_s),
      .valid_o (fifo_valid_s),
      .full_o  (fifo_full_s)
   );

   // Fetch FSM: redirect beats the fault check, which beats halt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH_RUN;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
      end else begin
         case (state_q)
            FETCH_RUN: begin
               if (redirect_valid) begin
                  pc_q <= redirect_pc;
               end else if (pc_bad_s) begin
                  state_q    <= FETCH_FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= pc_q;
               end else if (halt_req) begin
                  state_q <= FETCH_HALT;
               end else if (space_s) begin
                  pc_q <= pc_q + ADDRESS_WIDTH'(PC_STEP);
               end
            end
            FETCH_HALT: begin
               if (redirect_valid) begin
                  pc_q <= redirect_pc;
               end else if (!halt_req) begin
                  state_q <= FETCH_RUN;
               end
            end
            FETCH_FAULT: begin
               if (redirect_valid) begin
                  pc_q    <= redirect_pc;
                  fault_q <= 1'b0;
                  state_q <= halt_req ? FETCH_HALT : FETCH_RUN;
               end
            end
            default: begin
               state_q <= FETCH_RUN;
               fault_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_address = pc_q;
   assign instr_valid  = fifo_valid_s;
   assign instr_out    = head_s.instr;
   assign instr_pc     = head_s.pc;
   assign fault        = fault_q;
   assign fault_pc     = fault_pc_q;

endmodule
